uart_fifo: RTL and testbench
============================

Name: uart_fifo

Overview:
Parametrised next-generation UART for the microcomp boards: 8N1/8E1/8O1/8x2 framing, runtime-programmable baud divisor, and independent RX and TX FIFOs.
- Sits on the 8-bit CPU bus as a 4-byte register window.
- Raises a level interrupt to the CPU.
- All logic runs on the rising edge of a single clock.

Parameters:
- CLKSPEED, 19000000, main clock frequency in Hz.
- BAUD, 115200, baud rate selected at reset.
- DEFAULT_DIV, CLKSPEED/BAUD, divisor loaded at reset (clocks per bit).
- FIFO_DEPTH_LOG2, 4, log2 of depth of each FIFO (RX and TX are the same depth; default 16 entries).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- a  in  2  register select.
- din  in  8  write data.
- dout  out  8  read data (combinational from a and current state).
- rnw  in  1  1 = read, 0 = write.
- cs  in  1  chip select; an access is taken on every clk edge with cs=1.
- rxd  in  1  serial input, asynchronous.
- txd  out  1  serial output.
- irq  out  1  interrupt request, active-high.

Behaviour:
- Register map, reads:
  - a=0 STATUS:
    - [0] rx_nempty
    - [1] tx_full
    - [2] tx_busy (shifter active or TX FIFO non-empty)
    - [3] overrun
    - [4] framing_err
    - [5] parity_err
    - [6] tx_empty (idle and TX FIFO empty)
    - [7] 0
  - a=1 RXDATA: RX FIFO head; reads 0 when empty. A read pops the FIFO on that edge; popping an empty FIFO is ignored.
  - a=2 DIVL; a=3 DIVH.
- Register map, writes:
  - a=0 CTRL:
    - [0] rx_ie
    - [1] tx_ie
    - [2] par_en
    - [3] par_odd
    - [4] stop2
    - [7] clr_err: write-1 clears bits 3..5; not stored.
  - a=1 TXDATA: pushes to TX FIFO; the byte is dropped silently when the FIFO is full.
  - a=2 / a=3: low / high byte of the 16-bit divisor.
- CTRL readback: not readable. The team keeps status at a=0 for compatibility with existing monitor code.
- Reset values:
  - txd=1, irq=0, dout follows the register map.
  - Both FIFOs empty; error flags 0; CTRL=0.
  - Divisor = DEFAULT_DIV.
- Divisor handling:
  - Effective divisor is max(div,2).
  - A new divisor takes effect at the next bit boundary; the bit in progress completes at the old rate.
- RX path:
  - rxd is passed through a 2-flop synchroniser.
  - IDLE: on a 1->0 edge of the synchronised rxd, go to START and load the counter with div/2.
  - START, when counter hits 0:
    - rxd still 0: go to DATA with counter=div-1.
    - rxd is 1: false start, return to IDLE with no flags set.
  - DATA: 8 samples, LSB first, one every div clocks.
  - PARITY (only when par_en): sample one bit.
    - Mismatch against even/odd parity sets parity_err.
  - STOP: sample one bit.
    - Sampled 0 sets framing_err.
    - The byte is pushed regardless of any error.
    - Return to IDLE. RX checks only one stop bit even when stop2 is set.
- RX FIFO:
  - Push when full: byte dropped, overrun set.
  - Push and CPU pop on the same edge while full: both happen, count unchanged, no overrun.
  - Pointers wrap modulo 2^FIFO_DEPTH_LOG2; the count is FIFO_DEPTH_LOG2+1 bits wide.
- TX path:
  - IDLE: txd=1. When the TX FIFO is non-empty, pop the head and go to START.
  - Frame sequence: START (0), DATA (LSB first), PARITY (if par_en), STOP (1), then STOP2 (1, if stop2).
  - Each bit lasts exactly div clocks.
  - Back-to-back frames: no idle gap beyond the stop bit(s).
  - CPU push and shifter pop on the same edge: both happen.
- irq = (rx_ie & rx_nempty) | (tx_ie & tx_empty). Registered; updates one clock after the underlying flag changes.
- CTRL framing changes mid-frame take effect at the next frame.
- Reset asserted mid-frame: all state is cleared immediately and txd returns to 1 asynchronously.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined: parity generation and checking as above; CTRL[2:3] are honoured and STATUS[5] is live.
- Undefined:
  - No parity logic is built; CTRL[2:3] are ignored.
  - STATUS[5] reads 0.
  - Frames are always 8N1 or 8N2.

Test Plan:
All scenarios use CLKSPEED=1152000, BAUD=115200 (div=10).
- Reset, then read a=0..3 -> STATUS=0x40, DIVL=0x0A, DIVH=0x00, txd=1, irq=0.
- Write TXDATA 0x55 then 0xA3 -> txd shows 0,1,0,1,0,1,0,1,0,1 (start, data, stop) then the 0xA3 frame with no gap; each bit is 10 clocks; STATUS[6] returns to 1 after 200 clocks.
- Drive 17 frames 0x00..0x10 into rxd with no reads -> STATUS[0]=1, [3]=1; 16 reads return 0x00..0x0F; write CTRL 0x80 -> STATUS[3]=0.
- Send a frame with stop bit 0 -> byte pushed, STATUS[4]=1. Drive a 3-clock low glitch on rxd -> nothing pushed, no flags set.
- UART_PARITY_EN defined, CTRL=0x0C (odd parity), TX 0x01 -> parity bit 0. RX 0x03 with parity bit 0 -> parity_err=1. RX 0x03 with parity bit 1 -> parity_err stays 0.
- CTRL=0x01, receive 0x42 -> irq rises 1 clock after rx_nempty; read RXDATA=0x42 -> irq falls. Pulse reset low mid-TX-frame -> txd=1 immediately and TX FIFO empty.

Source files
------------

// File: rtl/uart_fifo.sv
// uart_fifo: 8-bit bus UART with independent RX/TX FIFOs and a programmable bit divisor.
// Build option: define UART_PARITY_EN to include parity generation/checking (CTRL[3:2], STATUS[5]).
module uart_fifo #(
    parameter int unsigned CLKSPEED        = 19000000,
    parameter int unsigned BAUD            = 115200,
    parameter int unsigned DEFAULT_DIV     = CLKSPEED / BAUD,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] a,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       rnw,
    input  logic       cs,
    input  logic       rxd,
    output logic       txd,
    output logic       irq
);
    localparam int unsigned Depth = 2 ** FIFO_DEPTH_LOG2;
    localparam int unsigned Aw = FIFO_DEPTH_LOG2;
    localparam logic [Aw:0] CntFull = (Aw + 1)'(Depth);

    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop, TxStop2} tx_state_e;

    logic w_wr, w_rd;
    assign w_wr = cs & ~rnw;
    assign w_rd = cs & rnw;

    logic        r_rx_ie, r_tx_ie, r_stop2;
    logic [15:0] r_div;
    logic        w_par_en, w_par_odd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_ie <= 1'b0;
            r_tx_ie <= 1'b0;
            r_stop2 <= 1'b0;
            r_div   <= 16'(DEFAULT_DIV);
        end else if (w_wr) begin
            case (a)
                2'd0: begin
                    r_rx_ie <= din[0];
                    r_tx_ie <= din[1];
                    r_stop2 <= din[4];
                end
                2'd2:    r_div[7:0]  <= din;
                2'd3:    r_div[15:8] <= din;
                default: ;
            endcase
        end
    end

`ifdef UART_PARITY_EN
    logic r_par_en, r_par_odd;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
        end else if (w_wr && a == 2'd0) begin
            r_par_en  <= din[2];
            r_par_odd <= din[3];
        end
    end
    assign w_par_en  = r_par_en;
    assign w_par_odd = r_par_odd;
`else
    assign w_par_en  = 1'b0;
    assign w_par_odd = 1'b0;
`endif

    // Counters reload only at bit boundaries, so a divisor write never stretches the current bit.
    logic [15:0] w_div_eff, w_div_m1, w_div_half;
    assign w_div_eff  = (r_div < 16'd2) ? 16'd2 : r_div;
    assign w_div_m1   = w_div_eff - 16'd1;
    assign w_div_half = w_div_eff >> 1;

    logic r_rx_s1, r_rx_sync, r_rx_prev;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_s1   <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= rxd;
            r_rx_sync <= r_rx_s1;
            r_rx_prev <= r_rx_sync;
        end
    end

    // RX FIFO
    logic [7:0]    r_rx_mem [Depth];
    logic [Aw-1:0] r_rx_wp, r_rx_rp;
    logic [Aw:0]   r_rx_cnt;
    logic [7:0]    r_rx_shift;
    logic          w_rx_nempty, w_rx_full, w_rx_pop, w_rx_push, w_rx_push_ok;

    assign w_rx_nempty  = (r_rx_cnt != '0);
    assign w_rx_full    = (r_rx_cnt == CntFull);
    assign w_rx_pop     = w_rd && (a == 2'd1) && w_rx_nempty;
    assign w_rx_push_ok = w_rx_push && (!w_rx_full || w_rx_pop);

    always_ff @(posedge clk) begin
        if (w_rx_push_ok) r_rx_mem[r_rx_wp] <= r_rx_shift;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push_ok) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)     r_rx_rp <= r_rx_rp + 1'b1;
            case ({w_rx_push_ok, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
                2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // TX FIFO
    logic [7:0]    r_tx_mem [Depth];
    logic [Aw-1:0] r_tx_wp, r_tx_rp;
    logic [Aw:0]   r_tx_cnt;
    logic          w_tx_nempty, w_tx_full, w_tx_push, w_tx_pop;
    logic [7:0]    w_tx_head;

    assign w_tx_nempty = (r_tx_cnt != '0);
    assign w_tx_full   = (r_tx_cnt == CntFull);
    assign w_tx_push   = w_wr && (a == 2'd1) && !w_tx_full;
    assign w_tx_head   = r_tx_mem[r_tx_rp];

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
                2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // RX state machine
    rx_state_e   r_rx_state, w_rx_state_nxt;
    logic [15:0] r_rx_cnt_bit, w_rx_cnt_nxt;
    logic [2:0]  r_rx_bit, w_rx_bit_nxt;
    logic [7:0]  w_rx_shift_nxt;
    logic        r_rx_par_en, r_rx_par_odd, w_rx_par_en_nxt, w_rx_par_odd_nxt;
    logic        w_rx_tick, w_rx_frm_set, w_rx_par_set;

    assign w_rx_tick = (r_rx_cnt_bit == 16'd0);

    always_comb begin
        w_rx_state_nxt   = r_rx_state;
        w_rx_cnt_nxt     = r_rx_cnt_bit - 16'd1;
        w_rx_bit_nxt     = r_rx_bit;
        w_rx_shift_nxt   = r_rx_shift;
        w_rx_par_en_nxt  = r_rx_par_en;
        w_rx_par_odd_nxt = r_rx_par_odd;
        w_rx_push        = 1'b0;
        w_rx_frm_set     = 1'b0;
        w_rx_par_set     = 1'b0;
        case (r_rx_state)
            RxIdle: begin
                w_rx_cnt_nxt = r_rx_cnt_bit;
                if (r_rx_prev && !r_rx_sync) begin
                    w_rx_state_nxt   = RxStart;
                    w_rx_cnt_nxt     = w_div_half;
                    w_rx_par_en_nxt  = w_par_en;
                    w_rx_par_odd_nxt = w_par_odd;
                end
            end
            RxStart: if (w_rx_tick) begin
                w_rx_cnt_nxt   = w_div_m1;
                w_rx_bit_nxt   = 3'd0;
                w_rx_state_nxt = r_rx_sync ? RxIdle : RxData;
            end
            RxData: if (w_rx_tick) begin
                w_rx_cnt_nxt   = w_div_m1;
                w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
                w_rx_bit_nxt   = r_rx_bit + 3'd1;
                if (r_rx_bit == 3'd7) w_rx_state_nxt = r_rx_par_en ? RxParity : RxStop;
            end
            RxParity: if (w_rx_tick) begin
                w_rx_cnt_nxt   = w_div_m1;
                w_rx_par_set   = (r_rx_sync != (^r_rx_shift ^ r_rx_par_odd));
                w_rx_state_nxt = RxStop;
            end
            RxStop: if (w_rx_tick) begin
                w_rx_push      = 1'b1;
                w_rx_frm_set   = !r_rx_sync;
                w_rx_state_nxt = RxIdle;
            end
            default: w_rx_state_nxt = RxIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state   <= RxIdle;
            r_rx_cnt_bit <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_par_en  <= 1'b0;
            r_rx_par_odd <= 1'b0;
        end else begin
            r_rx_state   <= w_rx_state_nxt;
            r_rx_cnt_bit <= w_rx_cnt_nxt;
            r_rx_bit     <= w_rx_bit_nxt;
            r_rx_shift   <= w_rx_shift_nxt;
            r_rx_par_en  <= w_rx_par_en_nxt;
            r_rx_par_odd <= w_rx_par_odd_nxt;
        end
    end

    logic r_overrun, r_frm_err, r_par_err;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overrun <= 1'b0;
            r_frm_err <= 1'b0;
            r_par_err <= 1'b0;
        end else begin
            if (w_wr && a == 2'd0 && din[7]) begin
                r_overrun <= 1'b0;
                r_frm_err <= 1'b0;
                r_par_err <= 1'b0;
            end
            if (w_rx_push && w_rx_full && !w_rx_pop) r_overrun <= 1'b1;
            if (w_rx_frm_set) r_frm_err <= 1'b1;
            if (w_rx_par_set) r_par_err <= 1'b1;
        end
    end

    // TX state machine; framing options are latched per frame at load time.
    tx_state_e   r_tx_state, w_tx_state_nxt;
    logic [15:0] r_tx_cnt_bit, w_tx_cnt_nxt;
    logic [2:0]  r_tx_bit, w_tx_bit_nxt;
    logic [7:0]  r_tx_shift, w_tx_shift_nxt;
    logic        r_txd, w_txd_nxt;
    logic        r_tx_par_en, r_tx_par_bit, r_tx_stop2;
    logic        w_tx_par_en_nxt, w_tx_par_bit_nxt, w_tx_stop2_nxt;
    logic        w_tx_tick, w_tx_end;

    assign w_tx_tick = (r_tx_cnt_bit == 16'd0);

    always_comb begin
        w_tx_state_nxt   = r_tx_state;
        w_tx_cnt_nxt     = r_tx_cnt_bit - 16'd1;
        w_tx_bit_nxt     = r_tx_bit;
        w_tx_shift_nxt   = r_tx_shift;
        w_txd_nxt        = r_txd;
        w_tx_par_en_nxt  = r_tx_par_en;
        w_tx_par_bit_nxt = r_tx_par_bit;
        w_tx_stop2_nxt   = r_tx_stop2;
        w_tx_pop         = 1'b0;
        w_tx_end         = 1'b0;
        case (r_tx_state)
            TxIdle: w_tx_end = 1'b1;
            TxStart: if (w_tx_tick) begin
                w_tx_cnt_nxt   = w_div_m1;
                w_txd_nxt      = r_tx_shift[0];
                w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                w_tx_bit_nxt   = 3'd0;
                w_tx_state_nxt = TxData;
            end
            TxData: if (w_tx_tick) begin
                w_tx_cnt_nxt = w_div_m1;
                if (r_tx_bit == 3'd7) begin
                    w_txd_nxt      = r_tx_par_en ? r_tx_par_bit : 1'b1;
                    w_tx_state_nxt = r_tx_par_en ? TxParity : TxStop;
                end else begin
                    w_txd_nxt      = r_tx_shift[0];
                    w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                    w_tx_bit_nxt   = r_tx_bit + 3'd1;
                end
            end
            TxParity: if (w_tx_tick) begin
                w_tx_cnt_nxt   = w_div_m1;
                w_txd_nxt      = 1'b1;
                w_tx_state_nxt = TxStop;
            end
            TxStop: if (w_tx_tick) begin
                w_tx_cnt_nxt   = w_div_m1;
                w_tx_state_nxt = TxStop2;
                w_tx_end       = !r_tx_stop2;
            end
            TxStop2: w_tx_end = w_tx_tick;
            default: w_tx_end = 1'b1;
        endcase
        // Loading straight from the stop bit keeps back-to-back frames gap-free.
        if (w_tx_end) begin
            w_tx_state_nxt = TxIdle;
            w_txd_nxt      = 1'b1;
            if (w_tx_nempty) begin
                w_tx_pop         = 1'b1;
                w_tx_shift_nxt   = w_tx_head;
                w_tx_par_bit_nxt = ^w_tx_head ^ w_par_odd;
                w_tx_par_en_nxt  = w_par_en;
                w_tx_stop2_nxt   = r_stop2;
                w_txd_nxt        = 1'b0;
                w_tx_cnt_nxt     = w_div_m1;
                w_tx_state_nxt   = TxStart;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state   <= TxIdle;
            r_tx_cnt_bit <= '0;
            r_tx_bit     <= '0;
            r_tx_shift   <= '0;
            r_txd        <= 1'b1;
            r_tx_par_en  <= 1'b0;
            r_tx_par_bit <= 1'b0;
            r_tx_stop2   <= 1'b0;
        end else begin
            r_tx_state   <= w_tx_state_nxt;
            r_tx_cnt_bit <= w_tx_cnt_nxt;
            r_tx_bit     <= w_tx_bit_nxt;
            r_tx_shift   <= w_tx_shift_nxt;
            r_txd        <= w_txd_nxt;
            r_tx_par_en  <= w_tx_par_en_nxt;
            r_tx_par_bit <= w_tx_par_bit_nxt;
            r_tx_stop2   <= w_tx_stop2_nxt;
        end
    end

    assign txd = r_txd;

    logic w_tx_busy, w_tx_empty;
    assign w_tx_busy  = (r_tx_state != TxIdle) || w_tx_nempty;
    assign w_tx_empty = !w_tx_busy;

    always_comb begin
        dout = 8'h00;
        case (a)
            2'd0: dout = {1'b0, w_tx_empty, r_par_err, r_frm_err,
                          r_overrun, w_tx_busy, w_tx_full, w_rx_nempty};
            2'd1: dout = w_rx_nempty ? r_rx_mem[r_rx_rp] : 8'h00;
            2'd2: dout = r_div[7:0];
            2'd3: dout = r_div[15:8];
            default: dout = 8'h00;
        endcase
    end

    logic r_irq;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_irq <= 1'b0;
        else        r_irq <= (r_rx_ie & w_rx_nempty) | (r_tx_ie & w_tx_empty);
    end
    assign irq = r_irq;

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed self-checking bench for uart_fifo at div=10 (1152000 Hz / 115200 baud).
module tb_uart_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] a = 2'd0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       rnw = 1'b1;
    logic       cs = 1'b0;
    logic       rxd = 1'b1;
    logic       txd;
    logic       irq;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    logic mon_en = 1'b0;
    int   nempty_cyc = -1;
    int   irq_cyc = -1;

    logic tx_samp [201];
    logic st_samp [201];

    uart_fifo #(
        .CLKSPEED(1152000),
        .BAUD(115200),
        .FIFO_DEPTH_LOG2(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .a(a),
        .din(din),
        .dout(dout),
        .rnw(rnw),
        .cs(cs),
        .rxd(rxd),
        .txd(txd),
        .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (dout[0] && nempty_cyc < 0) nempty_cyc = cyc;
            if (irq && irq_cyc < 0) irq_cyc = cyc;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
        @(negedge clk);
        cs = 1'b1; rnw = 1'b0; a = addr; din = data;
        @(negedge clk);
        cs = 1'b0; rnw = 1'b1; a = 2'd0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [7:0] data);
        @(negedge clk);
        cs = 1'b1; rnw = 1'b1; a = addr;
        #1 data = dout;
        @(negedge clk);
        cs = 1'b0; a = 2'd0;
    endtask

    task automatic rx_frame(input logic [7:0] data, input logic use_par, input logic par_bit,
                            input logic stop_bit);
        @(negedge clk);
        rxd = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            repeat (10) @(negedge clk);
        end
        if (use_par) begin
            rxd = par_bit;
            repeat (10) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (10) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd_async: got %b want 1", txd); end
        reset = 1'b1;
        bus_read(2'd0, d);
        n_checks++;
        if (d !== 8'h40) begin n_fail++; $display("FAIL reset_status: got %h want 40", d); end
        bus_read(2'd2, d);
        n_checks++;
        if (d !== 8'h0A) begin n_fail++; $display("FAIL reset_divl: got %h want 0a", d); end
        bus_read(2'd3, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL reset_divh: got %h want 00", d); end
        bus_read(2'd1, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL reset_rxdata_empty: got %h want 00", d); end
        n_checks++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", txd); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    endtask

    task automatic test_divisor();
        logic [7:0] d;
        bus_write(2'd2, 8'h34);
        bus_write(2'd3, 8'h12);
        bus_read(2'd2, d);
        n_checks++;
        if (d !== 8'h34) begin n_fail++; $display("FAIL div_low: got %h want 34", d); end
        bus_read(2'd3, d);
        n_checks++;
        if (d !== 8'h12) begin n_fail++; $display("FAIL div_high: got %h want 12", d); end
        bus_write(2'd2, 8'h0A);
        bus_write(2'd3, 8'h00);
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp_bits;
        logic        ok;
        logic        bad;
        exp_bits = {1'b1, 8'hA3, 1'b0, 1'b1, 8'h55, 1'b0};
        @(negedge clk);
        cs = 1'b1; rnw = 1'b0; a = 2'd1; din = 8'h55;
        @(negedge clk);
        n_checks++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL tx_idle_before_pop: got %b want 1", txd); end
        din = 8'hA3;
        @(negedge clk);
        cs = 1'b0; rnw = 1'b1; a = 2'd0;
        for (int i = 0; i < 201; i++) begin
            tx_samp[i] = txd;
            st_samp[i] = dout[6];
            @(negedge clk);
        end
        for (int b = 0; b < 20; b++) begin
            ok = 1'b1;
            bad = exp_bits[b];
            for (int k = 0; k < 10; k++) begin
                if (tx_samp[b * 10 + k] !== exp_bits[b]) begin
                    ok = 1'b0;
                    bad = tx_samp[b * 10 + k];
                end
            end
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL tx_bit%0d: got %b want %b for all 10 clocks", b, bad, exp_bits[b]);
            end
        end
        n_checks++;
        if (st_samp[199] !== 1'b0) begin
            n_fail++; $display("FAIL tx_empty_during_stop: got %b want 0", st_samp[199]);
        end
        n_checks++;
        if (st_samp[200] !== 1'b1) begin
            n_fail++; $display("FAIL tx_empty_after_200: got %b want 1", st_samp[200]);
        end
    endtask

    task automatic test_rx_overrun();
        logic [7:0] d;
        int         errs;
        for (int f = 0; f < 17; f++) rx_frame(8'(f), 1'b0, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        bus_read(2'd0, d);
        n_checks++;
        if (d !== 8'h49) begin n_fail++; $display("FAIL overrun_status: got %h want 49", d); end
        errs = 0;
        for (int r = 0; r < 16; r++) begin
            bus_read(2'd1, d);
            n_checks++;
            if (d !== 8'(r)) begin
                n_fail++; $display("FAIL rx_order%0d: got %h want %h", r, d, 8'(r));
            end
        end
        bus_read(2'd0, d);
        n_checks++;
        if (d !== 8'h48) begin n_fail++; $display("FAIL drained_status: got %h want 48", d); end
        bus_write(2'd0, 8'h80);
        bus_read(2'd0, d);
        n_checks++;
        if (d !== 8'h40) begin n_fail++; $display("FAIL clr_err_status: got %h want 40", d); end
    endtask

    task automatic test_framing_glitch();
        logic [7:0] d;
        rx_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        bus_read(2'd0, d);
        n_checks++;
        if (d !== 8'h51) begin n_fail++; $display("FAIL framing_status: got %h want 51", d); end
        bus_read(2'd1, d);
        n_checks++;
        if (d !== 8'h5A) begin n_fail++; $display("FAIL framing_data: got %h want 5a", d); end
        bus_write(2'd0, 8'h80);
        @(negedge clk);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        bus_read(2'd0, d);
        n_checks++;
        if (d !== 8'h40) begin n_fail++; $display("FAIL glitch_status: got %h want 40", d); end
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        logic [7:0] d;
        int         wait_cnt;
        bus_write(2'd0, 8'h0C);
        bus_write(2'd1, 8'h01);
        wait_cnt = 0;
        while (txd !== 1'b0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        n_checks++;
        if (txd !== 1'b0) begin n_fail++; $display("FAIL par_tx_start: got %b want 0", txd); end
        repeat (15) @(negedge clk);
        n_checks++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL par_tx_d0: got %b want 1", txd); end
        repeat (80) @(negedge clk);
        n_checks++;
        if (txd !== 1'b0) begin n_fail++; $display("FAIL par_tx_parity: got %b want 0", txd); end
        repeat (10) @(negedge clk);
        n_checks++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL par_tx_stop: got %b want 1", txd); end
        repeat (20) @(negedge clk);
        rx_frame(8'h03, 1'b1, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        bus_read(2'd0, d);
        n_checks++;
        if (d[5] !== 1'b1) begin n_fail++; $display("FAIL par_err_set: got %b want 1", d[5]); end
        bus_read(2'd1, d);
        n_checks++;
        if (d !== 8'h03) begin n_fail++; $display("FAIL par_data0: got %h want 03", d); end
        bus_write(2'd0, 8'h8C);
        rx_frame(8'h03, 1'b1, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        bus_read(2'd0, d);
        n_checks++;
        if (d[5] !== 1'b0) begin n_fail++; $display("FAIL par_err_clear: got %b want 0", d[5]); end
        bus_read(2'd1, d);
        n_checks++;
        if (d !== 8'h03) begin n_fail++; $display("FAIL par_data1: got %h want 03", d); end
        bus_write(2'd0, 8'h80);
    endtask
`endif

    task automatic test_irq_reset();
        logic [7:0] d;
        bus_write(2'd0, 8'h01);
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b want 0", irq); end
        nempty_cyc = -1;
        irq_cyc = -1;
        mon_en = 1'b1;
        rx_frame(8'h42, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        n_checks++;
        if (nempty_cyc < 0 || irq_cyc != nempty_cyc + 1) begin
            n_fail++;
            $display("FAIL irq_latency: got irq at %0d, rx_nempty at %0d, want one cycle later",
                     irq_cyc, nempty_cyc);
        end
        bus_read(2'd1, d);
        n_checks++;
        if (d !== 8'h42) begin n_fail++; $display("FAIL irq_rxdata: got %h want 42", d); end
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold_one: got %b want 1", irq); end
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %b want 0", irq); end
        bus_write(2'd1, 8'h00);
        bus_write(2'd1, 8'h00);
        repeat (30) @(negedge clk);
        n_checks++;
        if (txd !== 1'b0) begin n_fail++; $display("FAIL pre_reset_txd: got %b want 0", txd); end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_mid_txd: got %b want 1", txd); end
        n_checks++;
        if (dout !== 8'h40) begin n_fail++; $display("FAIL reset_mid_status: got %h want 40", dout); end
        @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        n_checks++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL post_reset_txd: got %b want 1", txd); end
        bus_read(2'd0, d);
        n_checks++;
        if (d !== 8'h40) begin n_fail++; $display("FAIL post_reset_status: got %h want 40", d); end
    endtask

    initial begin
        test_reset();
        test_divisor();
        test_back_to_back();
        test_rx_overrun();
        test_framing_glitch();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        test_irq_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
